// File: rtl/mux_if_4to1.sv
// rtl/mux_if_4to1.sv - 4-to-1 mux with a registered output; optional o_par when MUX_IF_PARITY_EN is defined
module mux_if_4to1 #(
    parameter int width  = 4,
    parameter int swidth = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [width-1:0]  i0,
    input  logic [width-1:0]  i1,
    input  logic [width-1:0]  i2,
    input  logic [width-1:0]  i3,
    input  logic [swidth-1:0] sel,
`ifdef MUX_IF_PARITY_EN
    output logic              o_par,
`endif
    output logic [width-1:0]  o
);

    generate
        if (swidth != 2) begin : g_bad_swidth
            $error("mux_if_4to1: swidth must be 2");
        end
        if (width < 1 || width > 64) begin : g_bad_width
            $error("mux_if_4to1: width must be in 1..64");
        end
    endgenerate

    logic [width-1:0] o_d;
    logic [width-1:0] o_q;

    // An unknown select falls through to the final else and steers i3.
    always_comb begin
        if (sel == 2'd0) begin
            o_d = i0;
        end else if (sel == 2'd1) begin
            o_d = i1;
        end else if (sel == 2'd2) begin
            o_d = i2;
        end else begin
            o_d = i3;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            o_q <= '0;
        end else begin
            o_q <= o_d;
        end
    end

    assign o = o_q;

`ifdef MUX_IF_PARITY_EN
    logic par_q;

    // Parity is taken from the next value so it stays aligned with o.
    always_ff @(posedge clk) begin
        if (rst) begin
            par_q <= 1'b0;
        end else begin
            par_q <= ^o_d;
        end
    end

    assign o_par = par_q;
`endif

endmodule

// File: tb/tb_mux_if_4to1.sv
// tb/tb_mux_if_4to1.sv - directed self-checking bench for mux_if_4to1
module tb_mux_if_4to1;

    logic       clk;
    logic       rst;
    logic [3:0] i0, i1, i2, i3;
    logic [1:0] sel;
    logic [3:0] o;
`ifdef MUX_IF_PARITY_EN
    logic       o_par;
`endif

    int n_checks;
    int n_fail;

    mux_if_4to1 #(.width(4), .swidth(2)) dut (
        .clk   (clk),
        .rst   (rst),
        .i0    (i0),
        .i1    (i1),
        .i2    (i2),
        .i3    (i3),
        .sel   (sel),
`ifdef MUX_IF_PARITY_EN
        .o_par (o_par),
`endif
        .o     (o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] c, input logic [3:0] d,
                         input logic [1:0] s);
        i0  = a;
        i1  = b;
        i2  = c;
        i3  = d;
        sel = s;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        drive(4'hA, 4'h0, 4'h0, 4'h0, 2'd0);
        step();
        step();
        n_checks++;
        if (o !== 4'h0) begin
            n_fail++;
            $display("FAIL reset_o: got %h expected %h", o, 4'h0);
        end
`ifdef MUX_IF_PARITY_EN
        n_checks++;
        if (o_par !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_par: got %b expected %b", o_par, 1'b0);
        end
`endif
        rst = 1'b0;
        step();
        n_checks++;
        if (o !== 4'hA) begin
            n_fail++;
            $display("FAIL reset_release: got %h expected %h", o, 4'hA);
        end
    endtask

    task automatic test_sel0;
        drive(4'hA, 4'hB, 4'hC, 4'hD, 2'd0);
        step();
        n_checks++;
        if (o !== 4'hA) begin
            n_fail++;
            $display("FAIL sel0_first: got %h expected %h", o, 4'hA);
        end
        drive(4'hB, 4'hC, 4'hD, 4'hE, 2'd0);
        step();
        n_checks++;
        if (o !== 4'hB) begin
            n_fail++;
            $display("FAIL sel0_second: got %h expected %h", o, 4'hB);
        end
    endtask

    task automatic test_sel1;
        drive(4'hC, 4'hD, 4'hE, 4'hF, 2'd1);
        step();
        n_checks++;
        if (o !== 4'hD) begin
            n_fail++;
            $display("FAIL sel1_first: got %h expected %h", o, 4'hD);
        end
        drive(4'hD, 4'hE, 4'hF, 4'hA, 2'd1);
        step();
        n_checks++;
        if (o !== 4'hE) begin
            n_fail++;
            $display("FAIL sel1_second: got %h expected %h", o, 4'hE);
        end
    endtask

    task automatic test_sel2;
        drive(4'hE, 4'hF, 4'hA, 4'hB, 2'd2);
        step();
        n_checks++;
        if (o !== 4'hA) begin
            n_fail++;
            $display("FAIL sel2_first: got %h expected %h", o, 4'hA);
        end
        drive(4'hF, 4'hA, 4'hB, 4'hC, 2'd2);
        step();
        n_checks++;
        if (o !== 4'hB) begin
            n_fail++;
            $display("FAIL sel2_second: got %h expected %h", o, 4'hB);
        end
    endtask

    task automatic test_sel3;
        drive(4'hA, 4'hB, 4'hC, 4'hD, 2'd3);
        step();
        n_checks++;
        if (o !== 4'hD) begin
            n_fail++;
            $display("FAIL sel3_first: got %h expected %h", o, 4'hD);
        end
`ifdef MUX_IF_PARITY_EN
        n_checks++;
        if (o_par !== 1'b1) begin
            n_fail++;
            $display("FAIL sel3_first_par: got %b expected %b", o_par, 1'b1);
        end
`endif
        drive(4'hB, 4'hC, 4'hD, 4'hE, 2'd3);
        step();
        n_checks++;
        if (o !== 4'hE) begin
            n_fail++;
            $display("FAIL sel3_second: got %h expected %h", o, 4'hE);
        end
`ifdef MUX_IF_PARITY_EN
        n_checks++;
        if (o_par !== 1'b1) begin
            n_fail++;
            $display("FAIL sel3_second_par: got %b expected %b", o_par, 1'b1);
        end
`endif
    endtask

    task automatic test_back_to_back;
        // Select and data change together every edge; walk all four selects.
        drive(4'h1, 4'h2, 4'h4, 4'h8, 2'd0);
        step();
        n_checks++;
        if (o !== 4'h1) begin
            n_fail++;
            $display("FAIL b2b_s0: got %h expected %h", o, 4'h1);
        end
        drive(4'h3, 4'h6, 4'hC, 4'h9, 2'd2);
        step();
        n_checks++;
        if (o !== 4'hC) begin
            n_fail++;
            $display("FAIL b2b_s2: got %h expected %h", o, 4'hC);
        end
        drive(4'h7, 4'h5, 4'h0, 4'hF, 2'd1);
        step();
        n_checks++;
        if (o !== 4'h5) begin
            n_fail++;
            $display("FAIL b2b_s1: got %h expected %h", o, 4'h5);
        end
`ifdef MUX_IF_PARITY_EN
        n_checks++;
        if (o_par !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_s1_par: got %b expected %b", o_par, 1'b0);
        end
`endif
        drive(4'h7, 4'h5, 4'h0, 4'h7, 2'd3);
        step();
        n_checks++;
        if (o !== 4'h7) begin
            n_fail++;
            $display("FAIL b2b_s3: got %h expected %h", o, 4'h7);
        end
    endtask

    task automatic test_mid_reset;
        drive(4'h1, 4'h2, 4'hF, 4'h3, 2'd2);
        rst = 1'b1;
        step();
        n_checks++;
        if (o !== 4'h0) begin
            n_fail++;
            $display("FAIL midrst_zero: got %h expected %h", o, 4'h0);
        end
        rst = 1'b0;
        step();
        n_checks++;
        if (o !== 4'hF) begin
            n_fail++;
            $display("FAIL midrst_resume: got %h expected %h", o, 4'hF);
        end
    endtask

    task automatic test_hold;
        // Between edges: unselected inputs toggle and a short rst pulse occurs.
        #1;
        i0 = 4'h0;
        i1 = 4'h5;
        i3 = 4'hA;
        #1;
        rst = 1'b1;
        #1;
        rst = 1'b0;
        n_checks++;
        if (o !== 4'hF) begin
            n_fail++;
            $display("FAIL hold_between_edges: got %h expected %h", o, 4'hF);
        end
        step();
        n_checks++;
        if (o !== 4'hF) begin
            n_fail++;
            $display("FAIL hold_unselected: got %h expected %h", o, 4'hF);
        end
        i2 = 4'h6;
        #2;
        n_checks++;
        if (o !== 4'hF) begin
            n_fail++;
            $display("FAIL hold_selected_change: got %h expected %h", o, 4'hF);
        end
        step();
        n_checks++;
        if (o !== 4'h6) begin
            n_fail++;
            $display("FAIL hold_next_edge: got %h expected %h", o, 4'h6);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        drive(4'h0, 4'h0, 4'h0, 4'h0, 2'd0);
        test_reset();
        test_sel0();
        test_sel1();
        test_sel2();
        test_sel3();
        test_back_to_back();
        test_mid_reset();
        test_hold();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
